peripheral_spram_wb_slave: RTL and testbench
============================================

// Module: peripheral_spram_wb_slave
// PURPOSE
//  Wishbone B3 responder in front of the generic single-port RAM core.
//  Converts classic and registered-feedback burst cycles into byte-write-enabled
//  write strobes and read addresses, and returns read data from the RAM.
//  The RAM read port has one cycle of latency.
//  Sits between the SoC interconnect and the peripheral_spram_generic_wb RAM core.
// PARAMETERS
//  DEPTH  256            RAM depth in 32-bit words
//  AW     $clog2(DEPTH)  RAM word-address width
//  DW     32             data width (fixed; four byte lanes)
// PORTS
//  wb_clk_i    in   1      clock
//  wb_rst_i    in   1      reset, asynchronous, active-high
//  wb_adr_i    in   AW+2   byte address; bits [1:0] ignored
//  wb_dat_i    in   DW     write data
//  wb_sel_i    in   4      byte lane selects
//  wb_we_i     in   1      1=write, 0=read
//  wb_cyc_i    in   1      bus cycle
//  wb_stb_i    in   1      strobe
//  wb_cti_i    in   3      cycle type: 000 classic, 010 incrementing, 111 end of burst
//  wb_bte_i    in   2      burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_dat_o    out  DW     read data
//  wb_ack_o    out  1      acknowledge
//  wb_err_o    out  1      tied 0
//  wb_rty_o    out  1      tied 0
//  mem_we      out  4      per-byte write enable to the RAM
//  mem_din     out  DW     write data to the RAM (= wb_dat_i)
//  mem_waddr   out  AW     write word address
//  mem_raddr   out  AW     read word address
//  mem_dout    in   DW     RAM read data, valid one cycle after mem_raddr
// BEHAVIOUR
//  - Reset: wb_ack_o=0; wb_dat_o follows mem_dout. Reset clears ack immediately, including mid-burst.
//  - valid = wb_cyc_i & wb_stb_i. burst = valid & (wb_cti_i==010). Any other CTI, including 001, is handled as classic.
//  - Ack register, updated each clock:
//      ack <= valid & (burst ? 1 : ~ack).
//    Classic: one ack per access, 1 wait state. A held strobe therefore costs 2 cycles per beat.
//    Burst: ack rises one cycle after the first strobe, then stays high every cycle until the ack beat with cti=111.
//    ack then drops on the next clock.
//  - Dropping cyc or stb mid-burst clears ack on the next clock. No write is issued in that cycle.
//  - Writes: mem_we = sel_i & {4{valid & we_i & ack}}, and mem_waddr = adr_i[AW+1:2].
//    The write commits at the clock edge ending the acked cycle, so each acked beat writes exactly once.
//  - Reads: mem_raddr = (ack & burst & ~we_i) ? next(adr_i) : adr_i[AW+1:2].
//    wb_dat_o = mem_dout. Data is valid whenever ack is high on a read.
//  - Burst sequence: the master holds adr until it samples ack. The responder prefetches next(adr) during each ack beat.
//    Read and write bursts therefore both run at 1 beat/cycle after the first.
//  - next(a), in word units:
//      linear: a+1, wrapping modulo DEPTH.
//      wrapN: upper bits of a kept; low log2(N) bits incremented modulo N.
//  - Address past DEPTH: the high bits are truncated, so the access aliases. No error response.
//  - Mixed read/write within one burst is not supported. we_i must stay constant for the whole burst.
// STRUCTURE
//  - Package peripheral_spram_wb_pkg holds:
//      CTI constants: CTI_CLASSIC=3'b000, CTI_INC=3'b010, CTI_EOB=3'b111.
//      BTE constants: BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16.
//      Function wb_next_adr(adr, bte).
//  - Sub-module peripheral_spram_wb_adr_gen: combinational next-address generator using wb_next_adr.
//  - The ack register lives in the top module.
//  - The top module instantiates no RAM. The integrator connects its mem_* ports to peripheral_spram_generic_wb.
// TESTING
//  - Reference RAM model: 1-cycle read latency, byte writes.
//  - Classic write: adr 0x10, dat 0xA5A5_1234, sel 0011.
//      Then read 0x10 -> ack one cycle after stb; dat_o[15:0]=0x1234; upper bytes unchanged.
//  - Incrementing read burst, 4 beats at 0x20, last beat cti=111:
//      ack high for 4 consecutive cycles after 1 wait; data = mem[8],mem[9],mem[10],mem[11]; ack low next cycle.
//  - Wrap4 write burst from 0x0C, data 1..4:
//      mem[3]=1, mem[0]=2, mem[1]=3, mem[2]=4; mem[4] untouched.
//  - Linear burst at last word (DEPTH-1):
//      next beat addresses word 0.
//  - cyc dropped after 2 beats of an 8-beat write burst:
//      exactly 2 words written; ack=0 next cycle.
//  - wb_rst_i asserted mid read burst:
//      ack falls asynchronously with no clock edge.
//      After release, a new classic read completes normally.

Source files
------------

// File: rtl/peripheral_spram_wb_pkg.sv
// peripheral_spram_wb_pkg: Wishbone B3 cycle/burst type codes and burst address stepping.
package peripheral_spram_wb_pkg;
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;
   // Word address of the next beat; wrap modes roll only the low bits over.
   function automatic logic [31:0] wb_next_adr(input logic [31:0] adr, input logic [1:0] bte);
      return bte == BTE_WRAP4  ? {adr[31:2], adr[1:0] + 2'd1} :
             bte == BTE_WRAP8  ? {adr[31:3], adr[2:0] + 3'd1} :
             bte == BTE_WRAP16 ? {adr[31:4], adr[3:0] + 4'd1} : adr + 32'd1;
   endfunction
endpackage

// File: rtl/peripheral_spram_wb_adr_gen.sv
// peripheral_spram_wb_adr_gen: combinational next word address for a Wishbone burst.
module peripheral_spram_wb_adr_gen
   import peripheral_spram_wb_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic [AW-1:0] adr_i,
   input  logic [1:0]    bte_i,
   output logic [AW-1:0] nxt_o
);
   // Linear bursts wrap at DEPTH even when DEPTH is not a power of two.
   assign nxt_o = (bte_i == BTE_LINEAR && adr_i == AW'(DEPTH - 1)) ? '0
                : AW'(wb_next_adr(32'(adr_i), bte_i));
endmodule

// File: rtl/peripheral_spram_wb_slave.sv
// peripheral_spram_wb_slave: Wishbone B3 classic/burst responder driving a 1-cycle-latency single-port RAM.
module peripheral_spram_wb_slave
   import peripheral_spram_wb_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = 32
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [AW+1:0] wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [DW-1:0] wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o,
   output logic [3:0]    mem_we,
   output logic [DW-1:0] mem_din,
   output logic [AW-1:0] mem_waddr,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_dout
);
   logic          valid;
   logic          burst;
   logic          ack_q;
   logic          ack_d;
   logic [AW-1:0] word_adr;
   logic [AW-1:0] nxt_adr;
   logic          unused_byte_adr;
   assign unused_byte_adr = ^wb_adr_i[1:0];
   assign word_adr = wb_adr_i[AW+1:2];
   assign valid    = wb_cyc_i & wb_stb_i;
   assign burst    = valid & (wb_cti_i == CTI_INC);
   // Bursts keep ack asserted; classic cycles (and the end-of-burst beat) toggle it.
   assign ack_d    = valid & (burst | ~ack_q);
   peripheral_spram_wb_adr_gen #(.DEPTH(DEPTH), .AW(AW)) u_adr_gen (
      .adr_i (word_adr),
      .bte_i (wb_bte_i),
      .nxt_o (nxt_adr)
   );
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) ack_q <= 1'b0;
      else          ack_q <= ack_d;
   end
   assign wb_ack_o  = ack_q;
   assign wb_err_o  = 1'b0;
   assign wb_rty_o  = 1'b0;
   assign wb_dat_o  = mem_dout;
   assign mem_din   = wb_dat_i;
   assign mem_waddr = word_adr;
   assign mem_we    = wb_sel_i & {4{valid & wb_we_i & ack_q}};
   // Prefetch the following beat so read bursts sustain one beat per cycle.
   assign mem_raddr = (ack_q & burst & ~wb_we_i) ? nxt_adr : word_adr;
endmodule

// File: tb/tb_peripheral_spram_wb_slave.sv
// tb_peripheral_spram_wb_slave: directed and randomized Wishbone traffic against a reference memory model.
module tb_peripheral_spram_wb_slave;
   localparam int DEPTH = 256;
   localparam int AW    = 8;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW+1:0] wb_adr = '0;
   logic [31:0]   wb_dat = '0;
   logic [3:0]    wb_sel = '0;
   logic          wb_we  = 1'b0;
   logic          wb_cyc = 1'b0;
   logic          wb_stb = 1'b0;
   logic [2:0]    wb_cti = '0;
   logic [1:0]    wb_bte = '0;
   logic [31:0]   dat_o;
   logic          ack_o, err_o, rty_o;
   logic [3:0]    mem_we;
   logic [31:0]   mem_din;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic [31:0]   ram_dout = '0;
   logic [31:0]   ram [DEPTH];
   logic [31:0]   ref_mem [DEPTH];
   int checks = 0;
   int errors = 0;

   peripheral_spram_wb_slave #(.DEPTH(DEPTH)) dut (
      .wb_clk_i (clk),      .wb_rst_i (rst),
      .wb_adr_i (wb_adr),   .wb_dat_i (wb_dat),
      .wb_sel_i (wb_sel),   .wb_we_i  (wb_we),
      .wb_cyc_i (wb_cyc),   .wb_stb_i (wb_stb),
      .wb_cti_i (wb_cti),   .wb_bte_i (wb_bte),
      .wb_dat_o (dat_o),    .wb_ack_o (ack_o),
      .wb_err_o (err_o),    .wb_rty_o (rty_o),
      .mem_we   (mem_we),   .mem_din  (mem_din),
      .mem_waddr(mem_waddr),.mem_raddr(mem_raddr),
      .mem_dout (ram_dout)
   );

   always #5 clk = ~clk;

   // Environment RAM: registered read, byte-lane writes.
   always @(posedge clk) begin
      ram_dout <= ram[mem_raddr];
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) ram[mem_waddr][8*b +: 8] = mem_din[8*b +: 8];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int nxt(input int a, input logic [1:0] bte);
      int n;
      n = 2 << bte;
      if (bte == 2'b00) return (a + 1) % DEPTH;
      return (a / n) * n + (a % n + 1) % n;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      wb_we  = 1'b0;
      wb_cti = 3'b000;
   endtask

   task automatic classic(input logic we, input int w, input logic [31:0] d, input logic [3:0] s, input logic [2:0] cti);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_cti = cti; wb_bte = 2'b00;
      wb_adr = {w[AW-1:0], 2'b00}; wb_dat = d; wb_sel = s;
      @(negedge clk);
      check("classic_wait_ack", 32'(ack_o), 32'd0);
      if (!we) check("classic_raddr", 32'(mem_raddr), 32'(w));
      tick();
      @(negedge clk);
      check("classic_ack", 32'(ack_o), 32'd1);
      if (we) begin
         check("classic_we", 32'(mem_we), 32'(s));
         ref_mem[w] = merge(ref_mem[w], d, s);
      end else check("classic_rdata", dat_o, ref_mem[w]);
      tick();
      idle();
      @(negedge clk);
      check("classic_ack_drop", 32'(ack_o), 32'd0);
      tick();
   endtask

   task automatic set_beat(input int w, input logic [2:0] cti, input int base, input int i);
      wb_adr = {w[AW-1:0], 2'b00};
      wb_cti = cti;
      wb_dat = base != 0 ? 32'(base + i) : $urandom;
      wb_sel = base != 0 ? 4'hF : 4'($urandom_range(0, 15));
   endtask

   // n beats; drop>0 abandons the burst after that many acked beats.
   task automatic burst(input logic we, input int start, input logic [1:0] bte, input int n, input int drop, input int base);
      int cur, beats;
      logic last;
      cur = start;
      beats = drop > 0 ? drop : n;
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_bte = bte;
      set_beat(cur, (drop == 0 && n == 1) ? 3'b111 : 3'b010, base, 0);
      @(negedge clk);
      check("burst_wait_ack", 32'(ack_o), 32'd0);
      tick();
      for (int i = 0; i < beats; i++) begin
         last = (drop == 0 && i == n - 1);
         @(negedge clk);
         check("burst_ack", 32'(ack_o), 32'd1);
         if (we) begin
            check("burst_we", 32'(mem_we), 32'(wb_sel));
            check("burst_waddr", 32'(mem_waddr), 32'(cur));
            ref_mem[cur] = merge(ref_mem[cur], wb_dat, wb_sel);
         end else begin
            check("burst_rdata", dat_o, ref_mem[cur]);
            check("burst_prefetch", 32'(mem_raddr), 32'(last ? cur : nxt(cur, bte)));
         end
         tick();
         cur = nxt(cur, bte);
         if (i + 1 < beats)
            set_beat(cur, (drop == 0 && i + 1 == n - 1) ? 3'b111 : 3'b010, base, i + 1);
      end
      idle();
      if (drop > 0) begin
         @(negedge clk);
         check("drop_ack_still_high", 32'(ack_o), 32'd1);
         check("drop_no_write", 32'(mem_we), 32'd0);
         tick();
      end
      @(negedge clk);
      check("burst_end_ack", 32'(ack_o), 32'd0);
      tick();
   endtask

   initial begin
      logic [31:0] keep4;
      logic [2:0]  cti_pick [3];
      int bad;
      cti_pick[0] = 3'b000; cti_pick[1] = 3'b001; cti_pick[2] = 3'b111;
      for (int i = 0; i < DEPTH; i++) begin
         ram[i] = $urandom;
         ref_mem[i] = ram[i];
      end
      #3;
      check("reset_ack", 32'(ack_o), 32'd0);
      check("reset_err", 32'(err_o), 32'd0);
      check("reset_rty", 32'(rty_o), 32'd0);
      tick();
      check("dat_follows_mem", dat_o, ram_dout);
      rst = 1'b0;
      tick();

      classic(1'b1, 32'h10 >> 2, 32'hA5A5_1234, 4'b0011, 3'b000);
      classic(1'b0, 32'h10 >> 2, 32'h0, 4'hF, 3'b000);
      check("classic_model_low_half", 32'(ref_mem[4][15:0]), 32'h1234);

      burst(1'b0, 32'h20 >> 2, 2'b00, 4, 0, 0);

      keep4 = ref_mem[4];
      burst(1'b1, 32'h0C >> 2, 2'b01, 4, 0, 1);
      check("wrap4_mem3", ram[3], 32'd1);
      check("wrap4_mem0", ram[0], 32'd2);
      check("wrap4_mem1", ram[1], 32'd3);
      check("wrap4_mem2", ram[2], 32'd4);
      check("wrap4_mem4_untouched", ram[4], keep4);

      burst(1'b0, DEPTH - 1, 2'b00, 3, 0, 0);
      burst(1'b1, DEPTH - 1, 2'b00, 2, 0, 0);

      burst(1'b1, 100, 2'b00, 8, 2, 0);

      // Reset in the middle of a read burst must clear ack without a clock edge.
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_bte = 2'b00;
      wb_cti = 3'b010; wb_adr = {8'd40, 2'b00};
      tick();
      @(negedge clk);
      check("rst_burst_ack", 32'(ack_o), 32'd1);
      tick();
      wb_adr = {8'd41, 2'b00};
      #1 rst = 1'b1;
      #1;
      check("async_reset_ack", 32'(ack_o), 32'd0);
      idle();
      tick();
      rst = 1'b0;
      tick();
      classic(1'b0, 41, 32'h0, 4'hF, 3'b000);

      for (int t = 0; t < 30; t++) begin
         int kind, w;
         kind = $urandom_range(0, 3);
         w = $urandom_range(0, DEPTH - 1);
         case (kind)
            0: classic(1'b1, w, $urandom, 4'($urandom_range(0, 15)), cti_pick[$urandom_range(0, 2)]);
            1: classic(1'b0, w, 32'h0, 4'hF, cti_pick[$urandom_range(0, 2)]);
            2: burst(1'b1, w, 2'($urandom_range(0, 3)), $urandom_range(1, 8), 0, 0);
            default: burst(1'b0, w, 2'($urandom_range(0, 3)), $urandom_range(1, 8), 0, 0);
         endcase
      end

      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
      check("final_mem_mismatch_words", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
